aes_iter_enc: RTL and testbench
===============================

Name: aes_iter_enc

Overview:
Iterative AES encryption core with a parametrised key size (AES-128 / AES-256). It computes one round per clock, expands the key on the fly, and uses valid/ready handshakes on input and output. It is the area-reduced successor to the fully unrolled aes_128 pipeline and is meant for low-throughput channels that need back-pressure.

Parameters:
KEY_BITS, 128, key length; legal values 128 or 256; any other value is an elaboration error (192 is unsupported).
NR, derived (10 for 128, 14 for 256), round count; not overridable.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  block and key present on state_in/key_in.
in_ready  out  1  core can accept a block.
state_in  in  128  plaintext; FIPS-197 byte order, bits [127:120] = byte 0.
key_in  in  KEY_BITS  cipher key; [KEY_BITS-1:KEY_BITS-8] = key byte 0.
out_valid  out  1  ciphertext available.
out_ready  in  1  downstream accepts ciphertext.
out  out  128  ciphertext; same byte order as state_in.
busy  out  1  high in ROUND state.

Behaviour:
- FSM states: IDLE, ROUND, DONE. Reset values: state IDLE, out_valid=0, out=0, busy=0, round counter=0, internal state/key registers=0.
- in_ready = (fsm==IDLE). Accept when in_valid && in_ready at a clock edge.
- Accept edge (IDLE->ROUND):
  - state_reg <= state_in ^ key_in[KEY_BITS-1:KEY_BITS-128] (initial AddRoundKey).
  - Key window register loads key_in.
  - rcnt <= 1.
- ROUND, each edge: apply one round with round key rcnt; rcnt++.
  - Rounds 1..NR-1: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round NR omits MixColumns.
  - On the edge that executes round NR: out <= result, out_valid <= 1, FSM -> DONE.
- Latency: out_valid rises exactly NR clock edges after the accept edge (10 for AES-128, 14 for AES-256).
- Key schedule, on the fly, one 128-bit round key per cycle, FIPS-197 expansion:
  - AES-256: alternates RotWord+SubWord+Rcon words with SubWord-only words, using a 256-bit sliding window.
  - Rcon register starts at 0x01 and is doubled in GF(2^8) (xtime) at each RotWord step.
- DONE: out and out_valid are held stable while out_ready=0. On out_valid && out_ready: out_valid <= 0 and FSM -> IDLE; out keeps its last value.
- Throughput: NR+2 cycles per block with no back-pressure. There is no accept in the same cycle as an out handshake.
- state_in/key_in are don't-care outside the accept edge; changes during ROUND/DONE have no effect.
- in_valid while not in_ready: ignored, no error. The upstream source must hold its data.
- rst_n low at any time, including mid-ROUND or in DONE with out_valid high: all registers return to reset values immediately (asynchronously). The in-flight block is discarded with no output.
- rst_n deassertion is synchronised externally; the first accept is possible on the first edge after release.

Decomposition:
- Package aes_pkg:
  - SBOX byte-table function.
  - xtime / gmul2 / gmul3 functions.
  - nr_of(KEY_BITS) function.
  - FSM state enum.
  - RCON_INIT constant 8'h01.
- Sub-module aes_round_comb: combinational single round (state, round key, is_final) -> next state. It instantiates 16 S-box lookups.
- Key-schedule step stays inline in aes_iter_enc.

Test Plan:
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out 3925841d02dc09fbdc118597196a0b32; out_valid exactly 10 edges after accept.
- KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. A back-to-back second block with zero key/pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e; in_ready low throughout ROUND/DONE.
- KEY_BITS=256, key 000102...1e1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089; latency 14 edges.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> out stable, in_ready=0. Raise out_ready -> one handshake, then in_ready=1 on the next cycle.
- Stimulus churn: toggle state_in/key_in randomly during ROUND -> result unchanged from the vector above.
- Reset mid-operation: assert rst_n=0 at round 5 -> out_valid=0, out=0, busy=0, in_ready=1 after release. A fresh vector then encrypts correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative encryption core.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic int nr_of(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] din,
    input  logic [127:0] rkey,
    input  logic         is_final,
    output logic [127:0] dout
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte i sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign sb[i] = sbox(din[127-8*i -: 8]);
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[4*c+r] = sb[4*((c+r)%4)+r];
        end
        assign mc[4*c]   = gmul2(sr[4*c]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
        assign mc[4*c+3] = gmul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_ark
        assign dout[127-8*i -: 8] = (is_final ? sr[i] : mc[i]) ^ rkey[127-8*i -: 8];
    end

endmodule

// File: rtl/aes_iter_enc.sv
// Iterative AES-128/256 encryptor: one round per clock, on-the-fly key expansion.
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   ROUND | executing rounds 1..NR, one per edge
//   DONE  | ciphertext held until out_ready
module aes_iter_enc
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        state_in,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out,
    output logic                busy
);

    localparam int NR = nr_of(KEY_BITS);
    localparam logic [3:0] NR_L = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_iter_enc: KEY_BITS must be 128 or 256");
    end

    fsm_t                state, nstate;
    logic [3:0]          rcnt;
    logic [7:0]          rcon;
    logic [127:0]        sreg;
    logic [KEY_BITS-1:0] kwin, kwin_nxt;
    logic [127:0]        rkey, rk_new, rnext, prev;
    logic [31:0]         tsrc, tword, w0, w1, w2, w3;
    logic                rot_step, accept, last;

    assign accept = in_valid && in_ready;
    assign last   = (state == ROUND) && (rcnt == NR_L);

    // Expansion step: next four words from the oldest 128 bits of the window.
    assign tsrc   = kwin[31:0];
    assign tword  = rot_step ? (subword({tsrc[23:0], tsrc[31:24]}) ^ {rcon, 24'h0})
                             : subword(tsrc);
    assign prev   = kwin[KEY_BITS-1 -: 128];
    assign w0     = prev[127:96] ^ tword;
    assign w1     = prev[95:64]  ^ w0;
    assign w2     = prev[63:32]  ^ w1;
    assign w3     = prev[31:0]   ^ w2;
    assign rk_new = {w0, w1, w2, w3};

    // AES-256 window holds {rk[r-1], rk[r]}; AES-128 window holds rk[r-1].
    if (KEY_BITS == 256) begin : g_k256
        assign rkey     = kwin[127:0];
        assign kwin_nxt = {kwin[127:0], rk_new};
        assign rot_step = rcnt[0];
    end else begin : g_k128
        assign rkey     = rk_new;
        assign kwin_nxt = rk_new;
        assign rot_step = 1'b1;
    end

    aes_round_comb u_round (
        .din      (sreg),
        .rkey     (rkey),
        .is_final (rcnt == NR_L),
        .dout     (rnext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (in_valid)  nstate = ROUND;
            ROUND:   if (last)      nstate = DONE;
            DONE:    if (out_ready) nstate = IDLE;
            default:                nstate = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state == ROUND);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            kwin      <= '0;
            rcnt      <= '0;
            rcon      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            sreg <= state_in ^ key_in[KEY_BITS-1 -: 128];
            kwin <= key_in;
            rcnt <= 4'd1;
            rcon <= RCON_INIT;
        end else if (state == ROUND) begin
            sreg <= rnext;
            kwin <= kwin_nxt;
            rcnt <= rcnt + 4'd1;
            if (rot_step) rcon <= xtime(rcon);
            if (last) begin
                out       <= rnext;
                out_valid <= 1'b1;
            end
        end else if (state == DONE && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_iter_enc.sv
// Self-checking bench for aes_iter_enc: AES-128 and AES-256 instances vs a byte-level AES model.
module tb_aes_iter_enc;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] state_in;
    logic [255:0] key_in;
    logic         out_ready;
    logic         iv_a, iv_b;
    logic         ir_a, ir_b, ov_a, ov_b, busy_a, busy_b;
    logic [127:0] out_a, out_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sbt [256];

    always #5 clk = ~clk;

    aes_iter_enc #(.KEY_BITS(128)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a),
        .state_in(state_in), .key_in(key_in[255:128]),
        .out_valid(ov_a), .out_ready(out_ready), .out(out_a), .busy(busy_a));

    aes_iter_enc #(.KEY_BITS(256)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
        .state_in(state_in), .key_in(key_in),
        .out_valid(ov_b), .out_ready(out_ready), .out(out_b), .busy(busy_b));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
    endfunction

    // nk = 4 uses key[255:128]; nk = 8 uses the whole key.
    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [7:0]  st [4][4];
        logic [7:0]  tmp [4][4];
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        logic [127:0] res;
        int nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[r][c] = sbt[st[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd == nr)
                        st[r][c] = tmp[r][c];
                    else
                        st[r][c] = gm(tmp[r][c], 8'h02) ^ gm(tmp[(r+1)%4][c], 8'h03)
                                 ^ tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
                    st[r][c] ^= w[4*rnd+c][31-8*r -: 8];
                end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = st[r][c];
        return res;
    endfunction

    // ---------------- DUT access ----------------
    function automatic logic ir(input bit s);   return s ? ir_b : ir_a;     endfunction
    function automatic logic ov(input bit s);   return s ? ov_b : ov_a;     endfunction
    function automatic logic bz(input bit s);   return s ? busy_b : busy_a; endfunction
    function automatic logic [127:0] dout(input bit s); return s ? out_b : out_a; endfunction

    // Called at a negedge; returns at the negedge where out_valid is first seen.
    task automatic encrypt(input bit s, input logic [127:0] pt, input logic [255:0] key, input bit churn,
                           output logic [127:0] ct, output int lat, output bit ir_seen);
        state_in = pt;
        key_in   = key;
        if (s) iv_b = 1'b1; else iv_a = 1'b1;
        @(negedge clk);
        iv_a = 1'b0; iv_b = 1'b0;
        lat = 0;
        ir_seen = ir(s);
        while (!ov(s) && lat < 40) begin
            if (churn) begin
                state_in = {$urandom, $urandom, $urandom, $urandom};
                key_in   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            lat++;
            if (ir(s)) ir_seen = 1'b1;
        end
        ct = dout(s);
        if (!ov(s)) lat = -1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    localparam logic [255:0] K1  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] K2  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; iv_a = 1'b0; iv_b = 1'b0; out_ready = 1'b0;
        state_in = '0; key_in = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (ir_a !== 1'b1 || ir_b !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b/%b want 1/1", ir_a, ir_b); end
        n_checks++; if (ov_a !== 1'b0 || ov_b !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b/%b want 0/0", ov_a, ov_b); end
        n_checks++; if (out_a !== 128'h0 || out_b !== 128'h0) begin n_fail++; $display("FAIL reset_out got %h/%h want 0", out_a, out_b); end
        n_checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b/%b want 0/0", busy_a, busy_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips128();
        logic [127:0] ct; int lat; bit irs;
        encrypt(1'b0, P1, K1, 1'b0, ct, lat, irs);
        n_checks++; if (ct !== C1) begin n_fail++; $display("FAIL fips128_ct got %h want %h", ct, C1); end
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL fips128_latency got %0d want 10", lat); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL fips128_busy_done got %b want 0", busy_a); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [127:0] ct; int lat; bit irs;
        encrypt(1'b0, P2, K2, 1'b0, ct, lat, irs);
        n_checks++; if (ct !== C2) begin n_fail++; $display("FAIL b2b_first_ct got %h want %h", ct, C2); end
        n_checks++; if (irs !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_busy got %b want 0", irs); end
        drain();
        n_checks++; if (ir_a !== 1'b1 || ov_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got in_ready=%b out_valid=%b want 1/0", ir_a, ov_a); end
        encrypt(1'b0, 128'h0, 256'h0, 1'b0, ct, lat, irs);
        n_checks++; if (ct !== CZ) begin n_fail++; $display("FAIL b2b_second_ct got %h want %h", ct, CZ); end
        n_checks++; if (irs !== 1'b0 || lat !== 10) begin n_fail++; $display("FAIL b2b_second_timing got in_ready_seen=%b lat=%0d want 0/10", irs, lat); end
        drain();
    endtask

    task automatic test_aes256();
        logic [127:0] ct; int lat; bit irs;
        encrypt(1'b1, P2, K3, 1'b0, ct, lat, irs);
        n_checks++; if (ct !== C3) begin n_fail++; $display("FAIL aes256_ct got %h want %h", ct, C3); end
        n_checks++; if (lat !== 14) begin n_fail++; $display("FAIL aes256_latency got %0d want 14", lat); end
        n_checks++; if (irs !== 1'b0) begin n_fail++; $display("FAIL aes256_in_ready_busy got %b want 0", irs); end
        drain();
    endtask

    task automatic test_back_pressure();
        logic [127:0] ct, pt, exp; logic [255:0] key; int lat; bit irs;
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        exp = ref_enc(pt, key, 8);
        encrypt(1'b1, pt, key, 1'b0, ct, lat, irs);
        n_checks++; if (ct !== exp) begin n_fail++; $display("FAIL bp_ct got %h want %h", ct, exp); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_b !== exp || ov_b !== 1'b1 || ir_b !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d got out=%h ov=%b ir=%b want out=%h ov=1 ir=0", i, out_b, ov_b, ir_b, exp);
            end
        end
        drain();
        n_checks++; if (ir_b !== 1'b1 || ov_b !== 1'b0) begin n_fail++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", ir_b, ov_b); end
        n_checks++; if (out_b !== exp) begin n_fail++; $display("FAIL bp_out_kept got %h want %h", out_b, exp); end
    endtask

    task automatic test_churn();
        logic [127:0] ct; int lat; bit irs;
        encrypt(1'b1, P2, K3, 1'b1, ct, lat, irs);
        n_checks++; if (ct !== C3 || lat !== 14) begin n_fail++; $display("FAIL churn256 got %h lat=%0d want %h lat=14", ct, lat, C3); end
        drain();
        encrypt(1'b0, P1, K1, 1'b1, ct, lat, irs);
        n_checks++; if (ct !== C1 || lat !== 10) begin n_fail++; $display("FAIL churn128 got %h lat=%0d want %h lat=10", ct, lat, C1); end
        drain();
    endtask

    task automatic test_random();
        logic [127:0] ct, pt, exp; logic [255:0] key; int lat; bit irs;
        for (int i = 0; i < 8; i++) begin
            bit s = i[0];
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            exp = ref_enc(pt, key, s ? 8 : 4);
            encrypt(s, pt, key, 1'b0, ct, lat, irs);
            n_checks++;
            if (ct !== exp || lat !== (s ? 14 : 10)) begin
                n_fail++;
                $display("FAIL random_%0d k%0d got %h lat=%0d want %h", i, s ? 256 : 128, ct, lat, exp);
            end
            drain();
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] ct; int lat; bit irs; bit seen_ov;
        state_in = P2; key_in = K2; iv_a = 1'b1;
        @(negedge clk);
        iv_a = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy_a); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ov_a !== 1'b0 || out_a !== 128'h0 || busy_a !== 1'b0 || ir_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset got ov=%b out=%h busy=%b ir=%b want 0/0/0/1", ov_a, out_a, busy_a, ir_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ov_a !== 1'b0 || busy_a !== 1'b0) seen_ov = 1'b1;
        end
        n_checks++; if (seen_ov !== 1'b0 || ir_a !== 1'b1) begin n_fail++; $display("FAIL mid_discard got activity=%b ir=%b want 0/1", seen_ov, ir_a); end
        encrypt(1'b0, P1, K1, 1'b0, ct, lat, irs);
        n_checks++; if (ct !== C1 || lat !== 10) begin n_fail++; $display("FAIL mid_fresh got %h lat=%0d want %h lat=10", ct, lat, C1); end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));
        test_reset();
        test_fips128();
        test_back_to_back();
        test_aes256();
        test_back_pressure();
        test_churn();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
